subsample_strobe_gen: RTL

Parametrised decimation engine for the oscilloscope acquisition path. It converts a continuous stream of ADC samples into one output sample per block of 2^ACTIVE_ID input samples. In decimate mode each block is represented by its first sample; in peak mode each block is represented by its unsigned max and min. Rate and mode changes are applied only on block or frame boundaries, so the display never receives a partial block. It provides the same one-hot active-rate vector used by the timebase indicator logic.

---
 rtl/subsample_strobe_gen.sv | 134 +++++++++++++
 1 files changed

// File: rtl/subsample_strobe_gen.sv
// Block decimator: one output per 2**ACTIVE_ID valid samples, either the block's first sample or its max/min.
// Requested rate/mode are staged and only take effect at block completion or frame start.
module subsample_strobe_gen #(
  parameter  int SEL_W   = 3,
  parameter  int DATA_W  = 12,
  localparam int N_RATES = 2 ** SEL_W,
  localparam int CNT_W   = (N_RATES - 1 < 1) ? 1 : N_RATES - 1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [SEL_W-1:0]   subsample_id_i,
  input  logic               peak_mode_i,
  input  logic               frame_start_i,
  input  logic               sample_valid_i,
  input  logic [DATA_W-1:0]  sample_in_i,
  output logic               out_valid_o,
  output logic [DATA_W-1:0]  data_out_o,
  output logic [DATA_W-1:0]  min_out_o,
  output logic [SEL_W-1:0]   active_id_o,
  output logic [N_RATES-1:0] rate_onehot_o,
  output logic               rate_changed_o
);

  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0]  first_q, first_d;
  logic [DATA_W-1:0]  max_q, max_d;
  logic [DATA_W-1:0]  min_q, min_d;
  logic [SEL_W-1:0]   pend_id_q, pend_id_d;
  logic               pend_mode_q, pend_mode_d;
  logic [SEL_W-1:0]   active_id_q, active_id_d;
  logic               active_mode_q, active_mode_d;
  logic [N_RATES-1:0] onehot_q, onehot_d;
  logic               out_valid_q, out_valid_d;
  logic [DATA_W-1:0]  data_out_q, data_out_d;
  logic [DATA_W-1:0]  min_out_q, min_out_d;
  logic               rate_changed_q, rate_changed_d;

  logic [CNT_W-1:0]   last_cnt;
  logic               blk_first;
  logic               blk_done;
  logic               apply;
  logic [DATA_W-1:0]  fold_first;
  logic [DATA_W-1:0]  fold_max;
  logic [DATA_W-1:0]  fold_min;

  always_comb begin
    // For the largest ID the shift wraps to zero, so the subtraction yields all ones.
    last_cnt   = (CNT_W'(1) << active_id_q) - CNT_W'(1);
    blk_first  = (cnt_q == '0);
    blk_done   = sample_valid_i && (cnt_q == last_cnt);
    apply      = blk_done || frame_start_i;
    fold_first = blk_first ? sample_in_i : first_q;
    fold_max   = (blk_first || (sample_in_i > max_q)) ? sample_in_i : max_q;
    fold_min   = (blk_first || (sample_in_i < min_q)) ? sample_in_i : min_q;
  end

  always_comb begin
    cnt_d          = cnt_q;
    first_d        = first_q;
    max_d          = max_q;
    min_d          = min_q;
    pend_id_d      = subsample_id_i;
    pend_mode_d    = peak_mode_i;
    active_id_d    = active_id_q;
    active_mode_d  = active_mode_q;
    onehot_d       = onehot_q;
    out_valid_d    = blk_done;
    data_out_d     = data_out_q;
    min_out_d      = min_out_q;
    rate_changed_d = 1'b0;

    if (apply) begin
      cnt_d = '0;
    end else if (sample_valid_i) begin
      cnt_d   = cnt_q + CNT_W'(1);
      first_d = fold_first;
      max_d   = fold_max;
      min_d   = fold_min;
    end

    // Completed block is emitted under the settings it was collected with.
    if (blk_done) begin
      data_out_d = active_mode_q ? fold_max : fold_first;
      min_out_d  = active_mode_q ? fold_min : fold_first;
    end

    if (apply) begin
      active_id_d    = pend_id_q;
      active_mode_d  = pend_mode_q;
      onehot_d       = N_RATES'(1) << pend_id_q;
      rate_changed_d = (pend_id_q != active_id_q) || (pend_mode_q != active_mode_q);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q          <= '0;
      first_q        <= '0;
      max_q          <= '0;
      min_q          <= '0;
      pend_id_q      <= '0;
      pend_mode_q    <= 1'b0;
      active_id_q    <= '0;
      active_mode_q  <= 1'b0;
      onehot_q       <= N_RATES'(1);
      out_valid_q    <= 1'b0;
      data_out_q     <= '0;
      min_out_q      <= '0;
      rate_changed_q <= 1'b0;
    end else begin
      cnt_q          <= cnt_d;
      first_q        <= first_d;
      max_q          <= max_d;
      min_q          <= min_d;
      pend_id_q      <= pend_id_d;
      pend_mode_q    <= pend_mode_d;
      active_id_q    <= active_id_d;
      active_mode_q  <= active_mode_d;
      onehot_q       <= onehot_d;
      out_valid_q    <= out_valid_d;
      data_out_q     <= data_out_d;
      min_out_q      <= min_out_d;
      rate_changed_q <= rate_changed_d;
    end
  end

  assign out_valid_o    = out_valid_q;
  assign data_out_o     = data_out_q;
  assign min_out_o      = min_out_q;
  assign active_id_o    = active_id_q;
  assign rate_onehot_o  = onehot_q;
  assign rate_changed_o = rate_changed_q;

endmodule
